// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 instruction encoder feeding a 4-deep output FIFO with address/word counters
module instr_encoder (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [3:0]  CLASS,
    input  logic [4:0]  RD,
    input  logic [4:0]  RS1,
    input  logic [4:0]  RS2,
    input  logic [2:0]  FUNCT3,
    input  logic [6:0]  FUNCT7,
    input  logic [4:0]  FUNCT5,
    input  logic [20:0] IMM,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA,
    output logic [31:0] OUT_ADDR,
    output logic [15:0] WORDS_OUT,
    output logic        ERR
);
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_FSW   = 7'b0100111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_FCOMP = 7'b1010011;

    logic [31:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [31:0] enc_word;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        case (CLASS)
            4'd0:    enc_word = {IMM[11:0], RS1, FUNCT3, RD, OP_LW};
            4'd1:    enc_word = {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OP_SW};
            4'd2:    enc_word = {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OP_BEQ};
            4'd3:    enc_word = {FUNCT7, RS2, RS1, FUNCT3, RD, OP_R};
            4'd4:    enc_word = {IMM[11:0], RS1, FUNCT3, RD, OP_I};
            4'd5:    enc_word = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OP_JAL};
            4'd6:    enc_word = {IMM[11:0], RS1, FUNCT3, RD, OP_FLW};
            4'd7:    enc_word = {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OP_FSW};
            4'd8:    enc_word = {FUNCT5, 2'b00, RS2, RS1, FUNCT3, RD, OP_FCOMP};
            default: legal    = 1'b0;
        endcase
    end

    assign REQ_READY = (count < 3'd4);
    assign OUT_VALID = (count != 3'd0);
    assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;
    assign accept    = REQ_VALID && REQ_READY;
    // CLR wins over any same-cycle handshake, so neither push nor pop may advance state.
    assign push      = accept && legal && !CLR;
    assign pop       = OUT_VALID && OUT_READY && !CLR;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OUT_ADDR  <= '0;
            WORDS_OUT <= '0;
            ERR       <= 1'b0;
        end else if (CLR) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OUT_ADDR  <= '0;
            WORDS_OUT <= '0;
            ERR       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 2'd1;
                OUT_ADDR  <= OUT_ADDR + 32'd4;
                WORDS_OUT <= WORDS_OUT + 16'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
            if (accept && !legal) begin
                ERR <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed-vector bench for instr_encoder
module tb_instr_encoder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CLR = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [3:0]  CLASS = '0;
    logic [4:0]  RD = '0, RS1 = '0, RS2 = '0;
    logic [2:0]  FUNCT3 = '0;
    logic [6:0]  FUNCT7 = '0;
    logic [4:0]  FUNCT5 = '0;
    logic [20:0] IMM = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_DATA;
    logic [31:0] OUT_ADDR;
    logic [15:0] WORDS_OUT;
    logic        ERR;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_words;

    instr_encoder dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .CLASS(CLASS), .RD(RD), .RS1(RS1), .RS2(RS2), .FUNCT3(FUNCT3), .FUNCT7(FUNCT7),
        .FUNCT5(FUNCT5), .IMM(IMM), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR), .WORDS_OUT(WORDS_OUT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  f5;
        logic [20:0] imm;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic set_req(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] f5, input logic [20:0] imm);
        CLASS = cls; RD = rd; RS1 = rs1; RS2 = rs2;
        FUNCT3 = f3; FUNCT7 = f7; FUNCT5 = f5; IMM = imm;
        REQ_VALID = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        vectors++; if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", REQ_READY); end
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", OUT_VALID); end
        vectors++; if (OUT_DATA !== 32'h0) begin miscompares++; $display("FAIL rst_data got %h want 0", OUT_DATA); end
        vectors++; if (OUT_ADDR !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", OUT_ADDR); end
        vectors++; if (WORDS_OUT !== 16'h0) begin miscompares++; $display("FAIL rst_words got %h want 0", WORDS_OUT); end
        vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", ERR); end
        RST = 1'b0;
        exp_addr = 0; exp_words = 0;
    endtask

    task automatic test_lw_latency();
        OUT_READY = 1'b1;
        set_req(4'd0, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 5'd0, 21'd8);
        step();
        REQ_VALID = 1'b0;
        vectors++; if (OUT_VALID !== 1'b1) begin miscompares++; $display("FAIL lw_valid got %b want 1", OUT_VALID); end
        vectors++; if (OUT_DATA !== 32'h00812283) begin miscompares++; $display("FAIL lw_data got %h want 00812283", OUT_DATA); end
        vectors++; if (OUT_ADDR !== 32'h0) begin miscompares++; $display("FAIL lw_addr got %h want 0", OUT_ADDR); end
        step();
        OUT_READY = 1'b0;
        vectors++; if (WORDS_OUT !== 16'd1) begin miscompares++; $display("FAIL lw_words got %0d want 1", WORDS_OUT); end
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL lw_empty got %b want 0", OUT_VALID); end
        exp_addr = 4; exp_words = 1;
    endtask

    task automatic test_formats();
        vec_t v[10];
        v[0] = '{4'd1, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 5'd0, 21'd12, 32'h00512623, "sw"};
        v[1] = '{4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 5'd0, 21'd8, 32'h008000EF, "jal"};
        v[2] = '{4'd8, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0, 32'h002081D3, "fcomp"};
        v[3] = '{4'd2, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd8, 32'h00208463, "beq_pos"};
        v[4] = '{4'd2, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'h1FFFFC, 32'hFE208EE3, "beq_neg"};
        v[5] = '{4'd3, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 5'd0, 21'd0, 32'h402081B3, "sub"};
        v[6] = '{4'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 5'd0, 21'h155FFF, 32'hFFF00093, "addi_m1"};
        v[7] = '{4'd6, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 5'd0, 21'd8, 32'h00812287, "flw"};
        v[8] = '{4'd7, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 5'd0, 21'd12, 32'h00512627, "fsw"};
        v[9] = '{4'd5, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 5'd0, 21'h1FFFF8, 32'hFF9FF06F, "jal_neg"};
        for (int i = 0; i < 10; i++) begin
            set_req(v[i].cls, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].f5, v[i].imm);
            step();
            REQ_VALID = 1'b0;
            vectors++; if (OUT_DATA !== v[i].exp) begin miscompares++; $display("FAIL %s_data got %h want %h", v[i].name, OUT_DATA, v[i].exp); end
            vectors++; if (OUT_ADDR !== exp_addr) begin miscompares++; $display("FAIL %s_addr got %h want %h", v[i].name, OUT_ADDR, exp_addr); end
            OUT_READY = 1'b1;
            step();
            OUT_READY = 1'b0;
            exp_addr += 4; exp_words += 1;
            vectors++; if (WORDS_OUT !== exp_words) begin miscompares++; $display("FAIL %s_words got %0d want %0d", v[i].name, WORDS_OUT, exp_words); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [5];
        logic acc;
        CLR = 1'b1; step(); CLR = 1'b0;
        vectors++; if (OUT_ADDR !== 32'h0) begin miscompares++; $display("FAIL b2b_clr_addr got %h want 0", OUT_ADDR); end
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) exp_w[i] = 32'h00208033 | (32'(i + 1) << 7);
        for (int i = 0; i < 4; i++) begin
            set_req(4'd3, 5'(i + 1), 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0);
            vectors++; if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d got %b want 1", i, REQ_READY); end
            step();
        end
        set_req(4'd3, 5'd5, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0);
        vectors++; if (REQ_READY !== 1'b0) begin miscompares++; $display("FAIL b2b_full got %b want 0", REQ_READY); end
        step(); step();
        vectors++; if (REQ_READY !== 1'b0) begin miscompares++; $display("FAIL b2b_held got %b want 0", REQ_READY); end
        vectors++; if (OUT_DATA !== exp_w[0]) begin miscompares++; $display("FAIL b2b_stable got %h want %h", OUT_DATA, exp_w[0]); end
        OUT_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vectors++; if (OUT_DATA !== exp_w[k]) begin miscompares++; $display("FAIL b2b_order%0d got %h want %h", k, OUT_DATA, exp_w[k]); end
            vectors++; if (OUT_ADDR !== 32'(4 * k)) begin miscompares++; $display("FAIL b2b_addr%0d got %h want %h", k, OUT_ADDR, 32'(4 * k)); end
            acc = REQ_VALID && REQ_READY;
            step();
            if (acc) REQ_VALID = 1'b0;
        end
        OUT_READY = 1'b0;
        REQ_VALID = 1'b0;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got %b want 0", OUT_VALID); end
        vectors++; if (WORDS_OUT !== 16'd5) begin miscompares++; $display("FAIL b2b_words got %0d want 5", WORDS_OUT); end
    endtask

    task automatic test_illegal_and_clr();
        OUT_READY = 1'b0;
        set_req(4'd3, 5'd10, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0); step();
        set_req(4'd3, 5'd11, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0); step();
        set_req(4'd12, 5'd12, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0); step();
        REQ_VALID = 1'b0;
        vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL ill_err got %b want 1", ERR); end
        OUT_READY = 1'b1;
        step(); step();
        OUT_READY = 1'b0;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL ill_count got valid %b want 0", OUT_VALID); end
        vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL ill_sticky got %b want 1", ERR); end
        set_req(4'd0, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 5'd0, 21'd8); step();
        CLR = 1'b1;
        set_req(4'd0, 5'd6, 5'd2, 5'd0, 3'b010, 7'd0, 5'd0, 21'd8); step();
        CLR = 1'b0; REQ_VALID = 1'b0;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL clr_empty got %b want 0", OUT_VALID); end
        vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL clr_err got %b want 0", ERR); end
        vectors++; if (OUT_ADDR !== 32'h0) begin miscompares++; $display("FAIL clr_addr got %h want 0", OUT_ADDR); end
        vectors++; if (WORDS_OUT !== 16'h0) begin miscompares++; $display("FAIL clr_words got %h want 0", WORDS_OUT); end
        step();
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL clr_drop got %b want 0", OUT_VALID); end
    endtask

    task automatic test_reset_mid();
        OUT_READY = 1'b0;
        set_req(4'd3, 5'd7, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd0); step(); step();
        REQ_VALID = 1'b0;
        OUT_READY = 1'b1;
        #1 RST = 1'b1;
        #1;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", OUT_VALID); end
        vectors++; if (OUT_DATA !== 32'h0) begin miscompares++; $display("FAIL mid_data got %h want 0", OUT_DATA); end
        vectors++; if (WORDS_OUT !== 16'h0) begin miscompares++; $display("FAIL mid_words got %h want 0", WORDS_OUT); end
        step();
        RST = 1'b0;
        set_req(4'd1, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 5'd0, 21'd12);
        OUT_READY = 1'b0;
        step();
        REQ_VALID = 1'b0;
        vectors++; if (OUT_DATA !== 32'h00512623) begin miscompares++; $display("FAIL mid_first got %h want 00512623", OUT_DATA); end
        vectors++; if (OUT_ADDR !== 32'h0) begin miscompares++; $display("FAIL mid_addr got %h want 0", OUT_ADDR); end
    endtask

    initial begin
        test_reset();
        test_lw_latency();
        test_formats();
        test_back_to_back();
        test_illegal_and_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
